tv80_im2_intc: RTL
==================

// Module: tv80_im2_intc
// PURPOSE
//   Mode-2 (IM 2) interrupt controller for the tv80s core. Arbitrates N_IRQ peripheral requests by fixed
//   priority, drives int_n, supplies the vector byte on the CPU data-in mux during INTA, and retires
//   in-service levels by snooping RETI (ED 4D) opcode fetches. Sits between peripherals and the tv80s bus.
// PARAMETERS
//   N_IRQ     4      number of request lines, 1..8; index 0 = highest priority
//   VEC_BASE  8'h80  vector of irq[0]; irq[k] -> VEC_BASE+2*k; spurious -> VEC_BASE+2*N_IRQ; bit0 must be 0
// PORTS
//   clk        in   1      CPU clock; all state changes on rising edge
//   reset      in   1      asynchronous, active-high
//   irq        in   N_IRQ  request lines, synchronous to clk, rising-edge sensitive
//   m1_n       in   1      tv80s M1
//   mreq_n     in   1      tv80s MREQ
//   iorq_n     in   1      tv80s IORQ
//   rd_n       in   1      tv80s RD
//   di         in   8      byte presented to CPU on opcode fetch (snooped)
//   int_n      out  1      interrupt request to CPU, registered
//   vec_oe     out  1      high during INTA; data mux selects vec_o over memory/IO
//   vec_o      out  8      vector byte
//   in_service out  N_IRQ  levels currently being serviced
//   ack        out  N_IRQ  one-clock pulse on the acknowledged line
// BEHAVIOUR
//   Reset: pending=0, in_service=0, irq_q=0, int_n=1, vec_oe=0, vec_o=VEC_BASE, ack=0, seen_ed=0, state=IDLE.
//   Edge detect: pending[k] set when irq[k] & ~irq_q[k]; line held high across reset release is one edge.
//   Eligible: pending & ~mask, mask = all levels at/below highest-priority in_service bit (see CONFIG).
//   int_n <= ~(|eligible) while state==IDLE; forced 1 in ACK. Latency irq edge -> int_n low: 2 clocks.
//   FSM IDLE: clock with m1_n=0 & iorq_n=0 (INTA) -> winner w = lowest index eligible;
//     vec_o<=VEC_BASE+2*w, vec_oe<=1, pending[w]<=0, in_service[w]<=1, ack[w] pulse; -> ACK.
//     INTA with no eligible bit: vec_o<=VEC_BASE+2*N_IRQ, vec_oe<=1, no state bits change; -> ACK.
//   FSM ACK: vec_oe/vec_o held; first clock with iorq_n=1 -> vec_oe<=0, -> IDLE.
//   RETI snoop: opcode byte = di sampled on clock where m1_n=0 & mreq_n=0 & rd_n=0 & iorq_n=1, last such
//     clock of the cycle (captured on m1_n rising). Byte ED sets seen_ed; next fetch 4D with seen_ed set ->
//     clear highest-priority in_service bit; any other next fetch clears seen_ed. RETN (ED 45) clears nothing.
//   Simultaneous: new edge on irq[w] in the ack clock -> pending[w] stays 1 (set wins over clear).
//     RETI clear and eligibility recompute in same clock: eligibility uses post-clear in_service.
//   Reset mid-INTA: outputs return to reset values immediately (async); no ack pulse.
// CONFIGURATION
//   TV80_INTC_NESTING_EN defined: mask = in_service levels and all lower-priority levels; a strictly
//     higher-priority pending request asserts int_n while a lower level is in service (nesting).
//   Not defined: mask = all ones whenever |in_service; int_n stays high until every level is retired.
// TESTING
//   T1 irq[2] 0->1, CPU in IM2 with EI; INTA -> vec_o=84, vec_oe during INTA, ack=0100, in_service=0100, int_n=1.
//   T2 irq[3] and irq[1] rise same clock -> first INTA vec 82, ack[1]; RETI ED 4D -> in_service=0; second INTA vec 86.
//   T3 nesting: irq[2] serviced, then irq[0] rises -> with _EN int_n low, INTA vec 80, in_service=0101;
//      without _EN int_n stays 1 until RETI, then vec 80.
//   T4 spurious INTA (no pending) -> vec_o=88 (N_IRQ=4), in_service and pending unchanged.
//   T5 fetch ED 45 (RETN) and ED 00 4D -> in_service unchanged; ED 4D -> lowest set bit cleared.
//   T6 reset asserted during ACK -> int_n=1, vec_oe=0, pending=0, in_service=0 before next clock edge.

Source files
------------

// File: rtl/tv80_im2_intc_if.sv
`default_nettype none
// ============================================================================
// Module   : tv80_im2_intc_if
// Purpose  : tv80s bus signals shared between the CPU and the IM2 interrupt
//            controller.
//            master : CPU side. Drives the bus strobes and the fetched byte,
//                     and receives the interrupt request and the vector.
//            slave  : controller side. Snoops the strobes and di, and drives
//                     int_n, vec_oe and vec_o.
// Signals  : m1_n, mreq_n, iorq_n, rd_n  active-low tv80s strobes
//            di      [7:0]                byte on the CPU data-in bus
//            int_n                        interrupt request to the CPU
//            vec_oe                       vector drive enable (INTA)
//            vec_o   [7:0]                vector byte
// Revision : 1.0  initial release
// ============================================================================
interface tv80_im2_intc_if;
    logic       m1_n;
    logic       mreq_n;
    logic       iorq_n;
    logic       rd_n;
    logic [7:0] di;
    logic       int_n;
    logic       vec_oe;
    logic [7:0] vec_o;

    modport master (
        output m1_n, mreq_n, iorq_n, rd_n, di,
        input  int_n, vec_oe, vec_o
    );

    modport slave (
        input  m1_n, mreq_n, iorq_n, rd_n, di,
        output int_n, vec_oe, vec_o
    );
endinterface
`default_nettype wire

// File: rtl/tv80_im2_intc.sv
`default_nettype none
// ============================================================================
// Module   : tv80_im2_intc
// Purpose  : Mode-2 interrupt controller for the tv80s core.
//            - Arbitrates N_IRQ rising-edge requests by fixed priority
//              (index 0 is the highest priority).
//            - Drives int_n to the CPU.
//            - Supplies the vector byte during INTA.
//            - Retires in-service levels by snooping RETI (ED 4D) fetches.
// Params   : N_IRQ    request line count, 1..8
//            VEC_BASE vector of irq[0]; irq[k] -> VEC_BASE+2k,
//                     spurious -> VEC_BASE+2*N_IRQ (bit0 must be 0)
// Config   : TV80_INTC_NESTING_EN
//              defined   : a strictly higher-priority request may interrupt
//                          a lower in-service level.
//              undefined : no new request is raised until all levels retire.
// Ports    : clk, reset         clock, asynchronous active-high reset
//            irq[N_IRQ]         request lines (synchronous to clk)
//            bus (slave)        tv80s strobes, di snoop, int_n/vec_oe/vec_o
//            in_service[N_IRQ]  levels currently being serviced
//            ack[N_IRQ]         one-clock pulse on the acknowledged line
// Revision : 1.0  initial release
// ============================================================================
module tv80_im2_intc #(
    parameter int         N_IRQ    = 4,
    parameter logic [7:0] VEC_BASE = 8'h80
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [N_IRQ-1:0] irq,
    tv80_im2_intc_if.slave        bus,
    output logic      [N_IRQ-1:0] in_service,
    output logic      [N_IRQ-1:0] ack
);

    localparam logic [7:0] c_vec_spurious = VEC_BASE + 8'(2 * N_IRQ);
    localparam logic [7:0] c_op_ed        = 8'hED;
    localparam logic [7:0] c_op_4d        = 8'h4D;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t           r_state;
    logic [N_IRQ-1:0] r_irq_q;
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] r_in_service;
    logic [N_IRQ-1:0] r_ack;
    logic             r_int_n;
    logic             r_vec_oe;
    logic [7:0]       r_vec_o;
    logic             r_seen_ed;
    logic             r_fetch_seen;
    logic [7:0]       r_opcode;

    logic [N_IRQ-1:0] w_edge;
    logic             w_fetch;
    logic             w_fetch_done;
    logic             w_reti;
    logic             w_inta;
    logic [N_IRQ-1:0] w_isr_post;
    logic [N_IRQ-1:0] w_mask;
    logic [N_IRQ-1:0] w_eligible;
    logic             w_found;
    logic [2:0]       w_winner;
    logic [N_IRQ-1:0] w_win_onehot;
    logic [N_IRQ-1:0] w_take;

    assign w_edge = irq & ~r_irq_q;
    assign w_inta = ~bus.m1_n & ~bus.iorq_n;

    // Opcode fetch: the byte is re-captured on every fetch clock so the last
    // one of the cycle wins, then decoded on the first clock with m1_n high.
    assign w_fetch      = ~bus.m1_n & ~bus.mreq_n & ~bus.rd_n & bus.iorq_n;
    assign w_fetch_done = bus.m1_n & r_fetch_seen;
    assign w_reti       = w_fetch_done & r_seen_ed & (r_opcode == c_op_4d);

    // A RETI retires the highest-priority (lowest-index) in-service level.
    // Eligibility is computed from this post-retire view so a request that
    // becomes eligible by the retire is raised in the same clock.
    always_comb begin
        logic done;
        w_isr_post = r_in_service;
        done       = 1'b0;
        for (int k = 0; k < N_IRQ; k++) begin
            if (w_reti && r_in_service[k] && !done) begin
                w_isr_post[k] = 1'b0;
                done          = 1'b1;
            end
        end
    end

`ifdef TV80_INTC_NESTING_EN
    // Block the highest in-service level and everything below it.
    always_comb begin
        logic acc;
        w_mask = '0;
        acc    = 1'b0;
        for (int k = 0; k < N_IRQ; k++) begin
            acc       = acc | w_isr_post[k];
            w_mask[k] = acc;
        end
    end
`else
    // No nesting: everything is blocked while any level is in service.
    assign w_mask = {N_IRQ{|w_isr_post}};
`endif

    assign w_eligible = r_pending & ~w_mask;

    always_comb begin
        w_found      = 1'b0;
        w_winner     = 3'd0;
        w_win_onehot = '0;
        for (int k = 0; k < N_IRQ; k++) begin
            if (w_eligible[k] && !w_found) begin
                w_found         = 1'b1;
                w_winner        = 3'(k);
                w_win_onehot[k] = 1'b1;
            end
        end
    end

    // Level accepted this clock (none for a spurious INTA).
    assign w_take = (r_state == S_IDLE && w_inta && w_found) ? w_win_onehot : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_irq_q      <= '0;
            r_pending    <= '0;
            r_in_service <= '0;
            r_ack        <= '0;
            r_int_n      <= 1'b1;
            r_vec_oe     <= 1'b0;
            r_vec_o      <= VEC_BASE;
            r_seen_ed    <= 1'b0;
            r_fetch_seen <= 1'b0;
            r_opcode     <= 8'h00;
        end else begin
            r_irq_q <= irq;
            r_ack   <= w_take;

            // A new edge on the acknowledged line keeps it pending.
            r_pending    <= (r_pending & ~w_take) | w_edge;
            r_in_service <= w_isr_post | w_take;

            if (w_fetch) begin
                r_opcode     <= bus.di;
                r_fetch_seen <= 1'b1;
            end else if (w_fetch_done) begin
                r_fetch_seen <= 1'b0;
                r_seen_ed    <= (r_opcode == c_op_ed);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_inta) begin
                        r_state  <= S_ACK;
                        r_vec_oe <= 1'b1;
                        r_int_n  <= 1'b1;
                        if (w_found) begin
                            r_vec_o <= VEC_BASE + {4'b0000, w_winner, 1'b0};
                        end else begin
                            r_vec_o <= c_vec_spurious;
                        end
                    end else begin
                        r_int_n <= ~(|w_eligible);
                    end
                end
                S_ACK: begin
                    r_int_n <= 1'b1;
                    if (bus.iorq_n) begin
                        r_vec_oe <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.int_n  = r_int_n;
    assign bus.vec_oe = r_vec_oe;
    assign bus.vec_o  = r_vec_o;
    assign in_service = r_in_service;
    assign ack        = r_ack;

endmodule
`default_nettype wire
